// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC receive front end - flag/abort detection, zero destuffing,
// LSB-first octet assembly with frame start/end/abort/overflow reporting.
module hdlc_rx_deframer #(
  parameter int MAX_FRAME_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       Rx_Enable,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_AbortSignal,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_EndOfFrame,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow
);
  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  typedef enum logic {IDLE, OPEN} state_t;
  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d, data_q, data_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0] bits_q, bits_d, ones_q, ones_d, skip_q, skip_d;
  logic flag_q, flag_d, abd_q, abd_d, abs_q, abs_d, nb_q, nb_d, eof_q, eof_d, fe_q, fe_d, ovf_q, ovf_d;
  logic bit_out;

  always_comb begin
    shift_d = {shift_q[6:0], Rx};
    flag_d  = shift_q == 8'h7E;
    abd_d   = shift_d == 8'h7F;
    // the flag's first bit exits as it is recognised; skip covers the other seven
    skip_d  = flag_d ? 3'd7 : skip_q - {2'b0, skip_q != 3'd0};
    bit_out = shift_q[7];
    state_d = state_q;
    byte_d  = byte_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    abs_d   = 1'b0;
    nb_d    = 1'b0;
    eof_d   = 1'b0;
    fe_d    = 1'b0;
    if (state_q == IDLE) begin
      state_d = (flag_q && Rx_Enable) ? OPEN : IDLE;
    end else if (abd_q) begin
      state_d = IDLE;
      abs_d   = 1'b1;
    end else if (!Rx_Enable) begin
      state_d = IDLE;
    end else if (flag_q) begin
      eof_d  = cnt_q != '0 || bits_q != 3'd0;
      fe_d   = bits_q != 3'd0;
      cnt_d  = '0;
      bits_d = 3'd0;
      ones_d = 3'd0;
      ovf_d  = 1'b0;
    end else if (skip_q == 3'd0 && !flag_d) begin
      if (ones_q == 3'd5 && !bit_out) begin
        ones_d = 3'd0;
      end else begin
        ones_d = bit_out ? ones_q + {2'b0, ones_q != 3'd7} : 3'd0;
        byte_d = {bit_out, byte_q[7:1]};
        bits_d = bits_q + 3'd1;
        if (bits_q == 3'd7) begin
          if (cnt_q == BW'(MAX_FRAME_BYTES)) begin
            ovf_d = 1'b1;
          end else begin
            data_d = byte_d;
            nb_d   = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
    end
    if (state_d == IDLE) begin
      cnt_d  = '0;
      bits_d = 3'd0;
      ones_d = 3'd0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      shift_q <= 8'hFF;
      byte_q  <= 8'h00;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      bits_q  <= 3'd0;
      ones_q  <= 3'd0;
      skip_q  <= 3'd0;
      {flag_q, abd_q, abs_q, nb_q, eof_q, fe_q, ovf_q} <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      ones_q  <= ones_d;
      skip_q  <= skip_d;
      {flag_q, abd_q, abs_q, nb_q, eof_q, fe_q, ovf_q} <= {flag_d, abd_d, abs_d, nb_d, eof_d, fe_d, ovf_d};
    end
  end

  assign Rx_FlagDetect  = flag_q;
  assign Rx_AbortDetect = abd_q;
  assign Rx_ValidFrame  = state_q == OPEN;
  assign Rx_AbortSignal = abs_q;
  assign Rx_Data        = data_q;
  assign Rx_NewByte     = nb_q;
  assign Rx_EndOfFrame  = eof_q;
  assign Rx_FrameError  = fe_q;
  assign Rx_Overflow    = ovf_q;
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: frame scenarios checked cycle by cycle against a frame-level model,
// plus hand sequences for enable gating and asynchronous reset mid-frame.
module tb_hdlc_rx_deframer;
  localparam int MAXB = 4;
  localparam int N = 6000;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, en = 1'b1;
  logic flag_det, abort_det, valid, abort_sig, new_byte, eof, ferr, ovf;
  logic [7:0] data;
  int errors = 0, checks = 0;
  int c_nb, c_val, c_abs, c_abd, c_eof, c_fe, c_ovf;
  logic [7:0] last_data, exp_data = 8'h00;

  always #5 clk = ~clk;

  hdlc_rx_deframer #(.MAX_FRAME_BYTES(MAXB)) dut (
    .Clk(clk), .Rst(rst_n), .Rx(rx), .Rx_Enable(en),
    .Rx_FlagDetect(flag_det), .Rx_AbortDetect(abort_det), .Rx_ValidFrame(valid),
    .Rx_AbortSignal(abort_sig), .Rx_Data(data), .Rx_NewByte(new_byte),
    .Rx_EndOfFrame(eof), .Rx_FrameError(ferr), .Rx_Overflow(ovf)
  );

  typedef struct {
    int nbits; bit abort_end; bit use_pat; logic [31:0] pat;
    int nb; bit eof; bit fe; bit ovf;
  } vec_t;
  vec_t tbl[12];
  bit line[N];
  int nbits;
  bit e_flag[N], e_abd[N], e_val[N], e_abs[N], e_nb[N], e_eof[N], e_fe[N], e_ovf[N];
  logic [7:0] e_dat[N];
  int v_lo[24], v_hi[24];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(bit b);
    rx = b;
    @(posedge clk);
    #1;
    c_nb += int'(new_byte); c_val += int'(valid); c_abs += int'(abort_sig); c_abd += int'(abort_det);
    c_eof += int'(eof); c_fe += int'(ferr); c_ovf += int'(ovf);
    if (new_byte) last_data = data;
  endtask

  task automatic send(logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(v[i]);
  endtask

  task automatic zero_counts();
    {c_nb, c_val, c_abs, c_abd, c_eof, c_fe, c_ovf} = '0;
  endtask

  function automatic void put(bit b);
    line[nbits] = b;
    nbits++;
  endfunction

  function automatic void put_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) put(v[i]);
  endfunction

  // data bits LSB first, with a zero inserted after every run of five ones
  function automatic void put_data(int n, bit use_pat, logic [31:0] pat);
    int run = 0;
    bit b;
    for (int i = 0; i < n; i++) begin
      b = use_pat ? pat[i] : 1'($urandom_range(0, 1));
      put(b);
      run = b ? run + 1 : 0;
      if (run == 5) begin
        put(1'b0);
        run = 0;
      end
    end
  endfunction

  function automatic bit win(int t, logic [7:0] p);
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = t - 7 + k;
      if ((idx < 0 ? 1'b1 : line[idx]) != p[7 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // raw line bits s..last are one frame's content; effects of its end land at edge e_end
  function automatic void frame(int s, int last, int e_end, bit closed);
    int run = 0, n = 0, cnt = 0, ovf_at = -1;
    logic [7:0] acc = 8'h00;
    for (int i = s; i <= last; i++) begin
      if (run == 5 && !line[i]) begin
        run = 0;
        continue;
      end
      run = line[i] ? run + 1 : 0;
      acc[n % 8] = line[i];
      n++;
      if (n % 8 == 0) begin
        if (cnt == MAXB) begin
          if (ovf_at < 0) ovf_at = i + 8;
        end else begin
          e_nb[i + 8] = 1'b1;
          e_dat[i + 8] = acc;
          cnt++;
        end
      end
    end
    if (ovf_at >= 0) for (int e = ovf_at; e < e_end; e++) e_ovf[e] = 1'b1;
    if (closed && n > 0) begin
      e_eof[e_end] = 1'b1;
      e_fe[e_end] = (n % 8) != 0;
    end
  endfunction

  function automatic void run_model();
    int s = 0, from = -1;
    for (int e = 0; e < N; e++) begin
      {e_flag[e], e_abd[e], e_val[e], e_abs[e], e_nb[e], e_eof[e], e_fe[e], e_ovf[e]} = '0;
      e_dat[e] = 8'h00;
    end
    for (int t = 0; t < nbits; t++) begin
      e_abd[t] = win(t, 8'h7F);
      if (win(t, 8'h7E)) e_flag[t + 1] = 1'b1;
      if (from >= 0 && e_abd[t]) begin
        frame(s, t - 8, t + 1, 1'b0);
        e_abs[t + 1] = 1'b1;
        for (int e = from; e <= t; e++) e_val[e] = 1'b1;
        from = -1;
      end else if (win(t, 8'h7E)) begin
        if (from >= 0) frame(s, t - 8, t + 2, 1'b1);
        else from = t + 2;
        s = t + 1;
      end
    end
    if (from >= 0) for (int e = from; e < N; e++) e_val[e] = 1'b1;
  endfunction

  initial begin
    tbl[0]  = '{16, 1'b0, 1'b1, 32'h3CA5,   2, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8,  1'b0, 1'b1, 32'hFF,     1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{12, 1'b0, 1'b0, 32'h0,      1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{40, 1'b0, 1'b0, 32'h0,      4, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{4,  1'b1, 1'b0, 32'h0,      0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{20, 1'b1, 1'b0, 32'h0,      2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0,  1'b0, 1'b0, 32'h0,      0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32, 1'b0, 1'b0, 32'h0,      4, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{33, 1'b0, 1'b0, 32'h0,      4, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{48, 1'b0, 1'b0, 32'h0,      4, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{7,  1'b0, 1'b0, 32'h0,      0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{24, 1'b0, 1'b1, 32'hFFFFFF, 3, 1'b1, 1'b0, 1'b0};
    nbits = 0;
    for (int k = 0; k < 24; k++) begin
      v_lo[k] = nbits;
      repeat (2 + $urandom_range(0, 3)) put(1'b1);
      put_byte(8'h7E);
      put_data(tbl[k % 12].nbits, tbl[k % 12].use_pat, tbl[k % 12].pat);
      put_byte(tbl[k % 12].abort_end ? 8'h7F : 8'h7E);
      repeat (12) put(1'b1);
      v_hi[k] = nbits;
    end
    run_model();

    #12;
    check("reset state", {flag_det, abort_det, valid, abort_sig, new_byte, eof, ferr, ovf, data}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      zero_counts();
      for (int e = v_lo[k]; e < v_hi[k]; e++) begin
        tick(line[e]);
        if (e_nb[e]) exp_data = e_dat[e];
        check($sformatf("cycle %0d", e),
              {flag_det, abort_det, valid, abort_sig, new_byte, eof, ferr, ovf, data},
              {e_flag[e], e_abd[e], e_val[e], e_abs[e], e_nb[e], e_eof[e], e_fe[e], e_ovf[e], exp_data});
      end
      check($sformatf("vec %0d new bytes", k), c_nb, tbl[k % 12].nb);
      check($sformatf("vec %0d end of frame", k), c_eof, int'(tbl[k % 12].eof));
      check($sformatf("vec %0d frame error", k), c_fe, int'(tbl[k % 12].fe));
      check($sformatf("vec %0d overflow seen", k), c_ovf > 0, tbl[k % 12].ovf);
      check($sformatf("vec %0d abort signal", k), c_abs, 1);
    end

    en = 1'b0;
    send(8'h7E);
    tick(1'b1);
    check("flag while disabled", flag_det, 1);
    tick(1'b1);
    check("no open while disabled", valid, 0);
    en = 1'b1;
    send(8'h7E);
    tick(1'b1);
    tick(1'b1);
    check("open when enabled", valid, 1);
    tick(1'b1); tick(1'b0); tick(1'b1);
    en = 1'b0;
    zero_counts();
    tick(1'b1);
    check("disable closes frame", valid, 0);
    en = 1'b1;
    repeat (12) tick(1'b1);
    check("no abort pulse after disable", c_abs, 0);
    check("abort detect while idle", c_abd, 1);

    send(8'h7E);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1);
    check("open before reset", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset clears outputs", {flag_det, abort_det, valid, abort_sig, new_byte, eof, ferr, ovf, data}, 0);
    #1 rst_n = 1'b1;
    zero_counts();
    send(8'hA5);
    repeat (16) tick(1'b1);
    check("no bytes after reset", c_nb, 0);
    check("no frame after reset", c_val, 0);
    zero_counts();
    send(8'h7E);
    send(8'hA5);
    send(8'h7E);
    repeat (4) tick(1'b1);
    check("reopen byte count", c_nb, 1);
    check("reopen byte value", last_data, 8'hA5);
    check("reopen end of frame", c_eof, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
